// File: rtl/alu_pkg.sv
// Shared types for the ALU command issuer: operand/tag widths, opcodes,
// the issue FSM state and the tagged response record.
package alu_pkg;

   localparam int DATA_W = 16;
   localparam int OP_W   = 4;
   localparam int TAG_W  = 4;

   localparam logic [OP_W-1:0] OP_ADD    = 4'h0;
   localparam logic [OP_W-1:0] OP_SUB    = 4'h1;
   localparam logic [OP_W-1:0] OP_AND    = 4'h2;
   localparam logic [OP_W-1:0] OP_OR     = 4'h3;
   localparam logic [OP_W-1:0] OP_XOR    = 4'h4;
   localparam logic [OP_W-1:0] OP_NOT    = 4'h5;
   localparam logic [OP_W-1:0] OP_SHL    = 4'h6;
   localparam logic [OP_W-1:0] OP_SHR    = 4'h7;
   localparam logic [OP_W-1:0] OP_MUL    = 4'h8;
   localparam logic [OP_W-1:0] OP_CMP    = 4'h9;
   localparam logic [OP_W-1:0] OP_FP_ADD = 4'hA;
   localparam logic [OP_W-1:0] OP_FP_SUB = 4'hB;

   function automatic logic op_is_legal(input logic [OP_W-1:0] op);
      return op <= OP_FP_SUB;
   endfunction

   typedef enum logic {IDLE, ISSUE} state_t;

   typedef struct packed {
      logic [DATA_W-1:0] result;
      logic              zero;
      logic              carry;
      logic              fp_error;
      logic [TAG_W-1:0]  tag;
   } rsp_t;

endpackage

// File: rtl/alu_rsp_fifo.sv
// Synchronous FIFO of ALU responses; head reads as all-zero while empty.
module alu_rsp_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push,
   input  rsp_t        push_data,
   input  logic        pop,
   output rsp_t        head,
   output logic [AW:0] count,
   output logic        full,
   output logic        empty
);

   rsp_t          mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          push_en, pop_en;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign push_en = push && !full;
   assign pop_en  = pop && !empty;
   assign head    = empty ? '0 : mem[rd_ptr];

   // NOTE: storage is deliberately not reset; empty gates the head, so stale
   // entries are never observable and the array can map to plain RAM.
   always_ff @(posedge clk) begin
      if (push_en) mem[wr_ptr] <= push_data;
   end

   // NOTE: all state uses non-blocking assignment so every register samples
   // pre-edge values, independent of process ordering.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_en, pop_en})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issues tagged commands to a combinational ALU and queues tagged responses.
// Optional operand-A forwarding of the last result: define ALU_ISSUER_FWD_EN.
module alu_cmd_issuer
   import alu_pkg::*;
#(
   parameter int RSP_DEPTH = 4
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
`ifdef ALU_ISSUER_FWD_EN
   input  logic              cmd_fwd_a,
`endif
   input  logic [OP_W-1:0]   cmd_op,
   input  logic [DATA_W-1:0] cmd_a,
   input  logic [DATA_W-1:0] cmd_b,
   input  logic [TAG_W-1:0]  cmd_tag,
   output logic [OP_W-1:0]   alu_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   input  logic              alu_carry,
   input  logic              alu_fp_error,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_result,
   output logic              rsp_zero,
   output logic              rsp_carry,
   output logic              rsp_fp_error,
   output logic [TAG_W-1:0]  rsp_tag,
   output logic              busy,
   output logic [7:0]        err_count
);

   localparam int CNT_W = $clog2(RSP_DEPTH) + 1;

   state_t             state, state_nxt;
   logic               accept, push, pop;
   logic               illegal_q;
   logic [TAG_W-1:0]   tag_q;
   rsp_t               push_rsp, head;
   logic [CNT_W-1:0]   fifo_count;
   logic               fifo_full, fifo_empty;
   logic [DATA_W-1:0]  a_sel;
`ifdef ALU_ISSUER_FWD_EN
   logic [DATA_W-1:0]  last_result;
`endif

   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      push      = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = !fifo_full;
            if (cmd_valid && !fifo_full) state_nxt = ISSUE;
         end
         ISSUE: begin
            push      = 1'b1;
            state_nxt = IDLE;
         end
      endcase
   end

   assign accept = cmd_valid && cmd_ready;
   assign pop    = rsp_ready && !fifo_empty;

`ifdef ALU_ISSUER_FWD_EN
   assign a_sel = cmd_fwd_a ? last_result : cmd_a;
`else
   assign a_sel = cmd_a;
`endif

   // Illegal ops still occupy an ISSUE slot but report a fixed error record.
   always_comb begin
      push_rsp = '0;
      if (illegal_q) begin
         push_rsp.zero     = 1'b1;
         push_rsp.fp_error = 1'b1;
         push_rsp.tag      = tag_q;
      end else begin
         push_rsp.result   = alu_result;
         push_rsp.zero     = alu_zero;
         push_rsp.carry    = alu_carry;
         push_rsp.fp_error = alu_fp_error;
         push_rsp.tag      = tag_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         alu_op    <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         tag_q     <= '0;
         illegal_q <= 1'b0;
         err_count <= '0;
`ifdef ALU_ISSUER_FWD_EN
         last_result <= '0;
`endif
      end else begin
         state <= state_nxt;
         if (accept) begin
            alu_op    <= op_is_legal(cmd_op) ? cmd_op : OP_ADD;
            alu_a     <= a_sel;
            alu_b     <= cmd_b;
            tag_q     <= cmd_tag;
            illegal_q <= !op_is_legal(cmd_op);
         end
         if (push && push_rsp.fp_error && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
`ifdef ALU_ISSUER_FWD_EN
         if (push) last_result <= push_rsp.result;
`endif
      end
   end

   alu_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_rsp),
      .pop       (pop),
      .head      (head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign rsp_valid    = !fifo_empty;
   assign rsp_result   = head.result;
   assign rsp_zero     = head.zero;
   assign rsp_carry    = head.carry;
   assign rsp_fp_error = head.fp_error;
   assign rsp_tag      = head.tag;
   assign busy         = (state != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Scoreboard bench for alu_cmd_issuer: directed commands push expected
// responses, a monitor pops and compares on every response handshake.
module tb_alu_cmd_issuer;
   import alu_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cmd_valid, cmd_ready;
   logic [OP_W-1:0]   cmd_op;
   logic [DATA_W-1:0] cmd_a, cmd_b;
   logic [TAG_W-1:0]  cmd_tag;
   logic [OP_W-1:0]   alu_op;
   logic [DATA_W-1:0] alu_a, alu_b, alu_result;
   logic              alu_zero, alu_carry, alu_fp_error;
   logic              rsp_valid, rsp_ready;
   logic [DATA_W-1:0] rsp_result;
   logic              rsp_zero, rsp_carry, rsp_fp_error;
   logic [TAG_W-1:0]  rsp_tag;
   logic              busy;
   logic [7:0]        err_count;
`ifdef ALU_ISSUER_FWD_EN
   logic              cmd_fwd_a = 1'b0;
`endif

   int   total = 0;
   int   bad   = 0;
   rsp_t exp_q[$];
   logic [DATA_W:0] alu_wide;

   always #5 clk = ~clk;

   alu_cmd_issuer #(.RSP_DEPTH(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
`ifdef ALU_ISSUER_FWD_EN
      .cmd_fwd_a    (cmd_fwd_a),
`endif
      .cmd_op       (cmd_op),
      .cmd_a        (cmd_a),
      .cmd_b        (cmd_b),
      .cmd_tag      (cmd_tag),
      .alu_op       (alu_op),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_result   (alu_result),
      .alu_zero     (alu_zero),
      .alu_carry    (alu_carry),
      .alu_fp_error (alu_fp_error),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_result   (rsp_result),
      .rsp_zero     (rsp_zero),
      .rsp_carry    (rsp_carry),
      .rsp_fp_error (rsp_fp_error),
      .rsp_tag      (rsp_tag),
      .busy         (busy),
      .err_count    (err_count)
   );

   // Minimal combinational ALU for the ops exercised here; carry is the 17th bit.
   always_comb begin
      alu_wide     = '0;
      alu_fp_error = 1'b0;
      case (alu_op)
         OP_ADD:  alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
         OP_SUB:  alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
         OP_AND:  alu_wide = {1'b0, alu_a & alu_b};
         OP_OR:   alu_wide = {1'b0, alu_a | alu_b};
         OP_XOR:  alu_wide = {1'b0, alu_a ^ alu_b};
         default: alu_wide = {1'b0, alu_a};
      endcase
      alu_result = alu_wide[DATA_W-1:0];
      alu_carry  = alu_wide[DATA_W];
      alu_zero   = (alu_result == '0);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
      end
   endtask

   function automatic rsp_t mk(input logic [15:0] r, input logic z, input logic c,
                               input logic e, input logic [3:0] t);
      rsp_t x;
      x.result = r; x.zero = z; x.carry = c; x.fp_error = e; x.tag = t;
      return x;
   endfunction

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] tag, input bit exp_en, input rsp_t exp_rsp,
                        output time t_acc);
      int waited = 0;
      t_acc     = 0;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      cmd_tag   = tag;
      while (!cmd_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!cmd_ready) begin
         total++;
         bad++;
         $display("FAIL cmd_ready_timeout: tag=%0d still not ready after %0d cycles", tag, waited);
         cmd_valid = 1'b0;
         return;
      end
      if (exp_en) exp_q.push_back(exp_rsp);
      @(posedge clk);
      t_acc = $time;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // Monitor: inputs settle at the negedge, so sample just after it.
   initial begin
      rsp_t act, want;
      forever begin
         @(negedge clk);
         #1;
         if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            act = mk(rsp_result, rsp_zero, rsp_carry, rsp_fp_error, rsp_tag);
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_rsp: got 0x%0h, want no response", act);
            end else begin
               want = exp_q.pop_front();
               check("rsp", 32'(act), 32'(want));
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      time t0, t1, t2;
      logic [15:0] and_a [5];
      logic [15:0] and_r [5];
      int waited;
      and_a = '{16'h00FF, 16'h0F0F, 16'hF0F0, 16'hFFFF, 16'h1234};
      and_r = '{16'h00F0, 16'h0F00, 16'h00F0, 16'h0FF0, 16'h0230};

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_tag = '0;
      rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_err_count", err_count, 0);
      check("rst_alu_op", alu_op, 0);
      check("rst_alu_a", alu_a, 0);
      check("rst_alu_b", alu_b, 0);
      check("rst_rsp_fields", {rsp_result, rsp_zero, rsp_carry, rsp_fp_error, rsp_tag}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // ADD overflow, 2-cycle latency
      issue(OP_ADD, 16'hFFFF, 16'h0001, 4'd3, 1'b1, mk(16'h0000, 1, 1, 0, 3), t0);
      check("e0_rsp_valid", rsp_valid, 0);
      check("issue_cmd_ready", cmd_ready, 0);
      check("issue_busy", busy, 1);
      check("alu_a_loaded", alu_a, 16'hFFFF);
      @(negedge clk);
      check("e1_rsp_valid", rsp_valid, 1);
      @(negedge clk);
      check("alu_a_hold", alu_a, 16'hFFFF);
      check("alu_b_hold", alu_b, 16'h0001);

      // SUB with borrow, then back-to-back command: accept spacing is 2 cycles
      issue(OP_SUB, 16'h0005, 16'h0007, 4'd1, 1'b1, mk(16'hFFFE, 0, 1, 0, 1), t0);
      issue(OP_ADD, 16'h1234, 16'h0001, 4'd2, 1'b1, mk(16'h1235, 0, 0, 0, 2), t1);
      check("b2b_spacing", 32'(t1 - t0), 20);
      issue(OP_OR,  16'hF0F0, 16'h0F0F, 4'd4, 1'b1, mk(16'hFFFF, 0, 0, 0, 4), t0);
      issue(OP_XOR, 16'hAAAA, 16'hAAAA, 4'd5, 1'b1, mk(16'h0000, 1, 0, 0, 5), t0);
      repeat (3) @(negedge clk);

      // Fill the FIFO with rsp_ready low
      rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         issue(OP_AND, and_a[i], 16'h0FF0, 4'(6 + i), 1'b1, mk(and_r[i], 0, 0, 0, 4'(6 + i)), t0);
      @(negedge clk);
      check("full_cmd_ready", cmd_ready, 0);
      check("full_head_tag", rsp_tag, 6);
      fork
         issue(OP_AND, and_a[4], 16'h0FF0, 4'd10, 1'b1, mk(and_r[4], 0, 0, 0, 10), t2);
         begin
            repeat (3) @(negedge clk);
            check("full_stall_ready", cmd_ready, 0);
            check("head_stable", rsp_result, 16'h00F0);
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
         end
      join
      check("fifth_accepted", (t2 != 0), 1);
      rsp_ready = 1'b1;
      repeat (8) @(negedge clk);

      // Illegal opcode and err_count saturation
      issue(4'hD, 16'h1111, 16'h2222, 4'd9, 1'b1, mk(16'h0000, 1, 0, 1, 9), t0);
      check("illegal_alu_op", alu_op, OP_ADD);
      @(negedge clk);
      check("err_count_1", err_count, 1);
      for (int i = 0; i < 254; i++)
         issue(4'hC | 4'(i & 3), 16'h0001, 16'h0001, 4'(i), 1'b1, mk(16'h0000, 1, 0, 1, 4'(i)), t0);
      @(negedge clk);
      check("err_count_255", err_count, 255);
      for (int i = 0; i < 2; i++)
         issue(4'hF, 16'h0000, 16'h0000, 4'(i), 1'b1, mk(16'h0000, 1, 0, 1, 4'(i)), t0);
      @(negedge clk);
      check("err_count_sat", err_count, 255);
      repeat (3) @(negedge clk);

      // Reset while ISSUE: command dropped
      issue(OP_ADD, 16'h0001, 16'h0001, 4'd7, 1'b0, '0, t0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("rst_issue_rsp_valid", rsp_valid, 0);
      check("rst_issue_busy", busy, 0);
      repeat (2) @(negedge clk);
      check("post_rst_rsp_valid", rsp_valid, 0);
      check("post_rst_cmd_ready", cmd_ready, 1);
      check("post_rst_err_count", err_count, 0);

`ifdef ALU_ISSUER_FWD_EN
      issue(OP_ADD, 16'h0002, 16'h0003, 4'd1, 1'b1, mk(16'h0005, 0, 0, 0, 1), t0);
      cmd_fwd_a = 1'b1;
      issue(OP_ADD, 16'h7777, 16'h0001, 4'd2, 1'b1, mk(16'h0006, 0, 0, 0, 2), t0);
      cmd_fwd_a = 1'b0;
      check("fwd_alu_a", alu_a, 16'h0005);
`endif

      waited = 0;
      while (exp_q.size() != 0 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check("scoreboard_drained", exp_q.size(), 0);
      check("final_idle", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
